insn_fetch_responder: RTL and testbench

INSN_FETCH_RESPONDER -- requirements
Module: insn_fetch_responder

---
 rtl/insn_fetch_responder_pkg.sv | 18 +
 rtl/insn_rsp_fifo.sv | 52 +++++
 rtl/insn_fetch_responder.sv | 105 ++++++++++
 tb/tb_insn_fetch_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/insn_fetch_responder_pkg.sv
// Shared configuration for the instruction fetch responder: default widths,
// the byte-to-word address shift, and the response record type.
package cfg;

    localparam int ADDR_WIDTH      = 32;
    localparam int INSN_WIDTH      = 32;
    // Instructions are 4-byte words, so the word index starts at bit 2.
    localparam int INSN_ADDR_START = 2;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [INSN_WIDTH-1:0] insn_t;

    typedef struct packed {
        insn_t insn;
        logic  err;
    } fetch_rsp_t;

endpackage

// File: rtl/insn_rsp_fifo.sv
// Two-entry first-word-fall-through buffer for fetch responses.
// The head entry is visible on head whenever count is non-zero.
module insn_rsp_fifo
    import cfg::*;
#(
    parameter int DW = INSN_WIDTH + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    // Pointer and count update; the caller never pushes when full or pops when empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + 2'(push) - 2'(pop);
    end

    // Control state; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/insn_fetch_responder.sv
// Instruction fetch responder: a synchronous-read instruction store behind a
// valid/ready request channel and an in-order valid/ready response channel.
// One read stage plus a two-entry response buffer, capped at two outstanding
// responses in total.
module insn_fetch_responder
    import cfg::*;
#(
    parameter int ADDR_WIDTH = cfg::ADDR_WIDTH,
    parameter int INSN_WIDTH = cfg::INSN_WIDTH,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [INSN_WIDTH-1:0]        rsp_insn,
    output logic                         rsp_err,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_idx,
    input  logic [INSN_WIDTH-1:0]        ld_data
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [INSN_WIDTH-1:0] mem [MEM_WORDS];
    logic [INSN_WIDTH-1:0] rd_q;
    logic                  inflight_q, inflight_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0]      rd_idx;
    logic                  req_err;
    logic                  accept;
    logic [1:0]            occ;
    logic                  fifo_empty;
    logic                  rsp_pop;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [INSN_WIDTH:0]   stage_rsp;
    logic [INSN_WIDTH:0]   fifo_head;
    logic [INSN_WIDTH:0]   out_rsp;
    logic [1:0]            fifo_count;

    // Request decode, occupancy and response steering.
    always_comb begin
        word_addr  = req_addr >> INSN_ADDR_START;
        rd_idx     = word_addr[IDX_W-1:0];
        req_err    = (|req_addr[INSN_ADDR_START-1:0]) || (|(word_addr >> IDX_W));
        occ        = {1'b0, inflight_q} + fifo_count;
        // rst_n gates ready so nothing is accepted while reset is held.
        req_ready  = rst_n && (occ < 2'd2);
        accept     = req_valid && req_ready;
        fifo_empty = (fifo_count == 2'd0);
        // The read stage is older-than-nothing only when the buffer is empty,
        // so it is presented directly then; otherwise the buffer head goes first.
        stage_rsp  = {(err_q ? '0 : rd_q), err_q};
        out_rsp    = fifo_empty ? stage_rsp : fifo_head;
        rsp_valid  = !fifo_empty || inflight_q;
        rsp_pop    = rsp_valid && rsp_ready;
        fifo_pop   = rsp_pop && !fifo_empty;
        // The read stage lasts one cycle: it is either consumed directly or parked.
        fifo_push  = inflight_q && !(rsp_pop && fifo_empty);
        rsp_insn   = rsp_valid ? out_rsp[INSN_WIDTH:1] : '0;
        rsp_err    = rsp_valid && out_rsp[0];
        inflight_d = accept;
        err_d      = accept ? req_err : err_q;
    end

    // Single-port-write, single-port-read store; the read sees pre-write contents.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
        if (accept && !req_err) begin
            rd_q <= mem[rd_idx];
        end
    end

    // Read-stage control; reset discards any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    insn_rsp_fifo #(
        .DW (INSN_WIDTH + 1)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (stage_rsp),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_insn_fetch_responder.sv
// Bench for insn_fetch_responder: directed vector table, hand-written
// stall/collision/reset sequences, and a long randomized throttled run
// compared against a queue-based reference model.
module tb_insn_fetch_responder;
    import cfg::*;

    localparam int MW = 64;
    localparam int IW = $clog2(MW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    addr_t         req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    insn_t         rsp_insn;
    logic          rsp_err;
    logic          ld_en = 1'b0;
    logic [IW-1:0] ld_idx = '0;
    insn_t         ld_data = '0;

    always #5 clk = ~clk;

    insn_fetch_responder #(.MEM_WORDS(MW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_insn  (rsp_insn),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data)
    );

    typedef struct {
        addr_t addr;
        insn_t insn;
        logic  err;
    } vec_t;

    insn_t      mm [MW];
    fetch_rsp_t exp_q [$];
    fetch_rsp_t got_q [$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_acc = 0;
    bit         stall_prev = 1'b0;
    fetch_rsp_t held;
    vec_t       tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected response straight from the addressing rules and the model store.
    function automatic fetch_rsp_t model(input addr_t a);
        fetch_rsp_t r;
        if (a[1:0] != 2'b00 || (a >> 2) >= MW) begin
            r.insn = '0;
            r.err  = 1'b1;
        end else begin
            r.insn = mm[a[IW+1:2]];
            r.err  = 1'b0;
        end
        return r;
    endfunction

    // One clock: drive inputs after the falling edge, check before the rising edge.
    task automatic cycle(input logic v, input addr_t a, input logic rr,
                         input logic le, input logic [IW-1:0] li, input insn_t ld);
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
        ld_en     = le;
        ld_idx    = li;
        ld_data   = ld;
        #3;
        chk("req_ready", 32'(req_ready), 32'(exp_q.size() < 2));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
        if (rsp_valid && exp_q.size() > 0) begin
            chk("rsp_insn", rsp_insn, exp_q[0].insn);
            chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
        end
        if (stall_prev) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_insn", rsp_insn, held.insn);
            chk("hold_err", 32'(rsp_err), 32'(held.err));
        end
        if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            got_q.push_back('{insn: rsp_insn, err: rsp_err});
        end
        if (v && req_ready) begin
            exp_q.push_back(model(a));
            n_acc++;
        end
        if (le) mm[li] = ld;
        stall_prev = rsp_valid && !rsp_ready;
        held.insn  = rsp_insn;
        held.err   = rsp_err;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_insn", rsp_insn, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Preload the whole store
        for (int i = 0; i < MW; i++) begin
            insn_t w;
            w = (i < 4) ? insn_t'(32'h11111111 * (i + 1)) : insn_t'($urandom);
            cycle(1'b0, '0, 1'b1, 1'b1, IW'(i), w);
        end

        // Table-driven back-to-back requests
        tbl[0] = '{addr: 32'h0,      insn: 32'h11111111, err: 1'b0};
        tbl[1] = '{addr: 32'h4,      insn: 32'h22222222, err: 1'b0};
        tbl[2] = '{addr: 32'h8,      insn: 32'h33333333, err: 1'b0};
        tbl[3] = '{addr: 32'hC,      insn: 32'h44444444, err: 1'b0};
        tbl[4] = '{addr: 32'h6,      insn: 32'h0,        err: 1'b1};
        tbl[5] = '{addr: addr_t'(MW * 4), insn: 32'h0,   err: 1'b1};
        got_q.delete();
        for (int i = 0; i < 6; i++) cycle(1'b1, tbl[i].addr, 1'b1, 1'b0, '0, '0);
        idle(3);
        chk("tbl_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) begin
                chk("tbl_insn", got_q[i].insn, tbl[i].insn);
                chk("tbl_err", 32'(got_q[i].err), 32'(tbl[i].err));
            end
        end

        // Backpressure: two accepted, third stalls, then drains in order
        got_q.delete();
        n_acc = 0;
        cycle(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 32'h14, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 32'h18, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 32'h18, 1'b0, 1'b0, '0, '0);
        chk("stall_accepts", 32'(n_acc), 32'd2);
        chk("stall_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 10 && n_acc < 3; i++) cycle(1'b1, 32'h18, 1'b1, 1'b0, '0, '0);
        idle(4);
        chk("bp_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) chk("bp_order", got_q[i].insn, mm[4 + i]);
        end

        // Read-first collision on the same word
        got_q.delete();
        cycle(1'b1, 32'h8, 1'b1, 1'b1, IW'(2), 32'hDEADBEEF);
        cycle(1'b1, 32'h8, 1'b1, 1'b0, '0, '0);
        idle(3);
        chk("rf_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("rf_old", got_q[0].insn, 32'h33333333);
            chk("rf_new", got_q[1].insn, 32'hDEADBEEF);
        end

        // Reset with two responses outstanding
        cycle(1'b1, 32'h20, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 32'h24, 1'b0, 1'b0, '0, '0);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("pre_rst_occ_full", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_insn", rsp_insn, 32'd0);
        chk("rst_mid_err", 32'(rsp_err), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        stall_prev = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        got_q.delete();
        cycle(1'b1, 32'h8, 1'b1, 1'b0, '0, '0);
        idle(2);
        chk("rst_store_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("rst_store_kept", got_q[0].insn, 32'hDEADBEEF);

        // Randomized throttled traffic with concurrent loads
        n_acc = 0;
        for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
            addr_t a;
            logic  v, rr, le;
            a = addr_t'($urandom_range(0, MW * 4 + 31));
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            v  = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            le = ($urandom_range(0, 4) == 0);
            cycle(v, a, rr, le, IW'($urandom_range(0, MW - 1)), insn_t'($urandom));
        end
        chk("rand_requests", 32'(n_acc >= 10000), 32'd1);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
        chk("rand_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
